// File: rtl/kabeta_int_ctrl_pkg.sv
// Shared definitions for the kabeta interrupt controller: register map and FSM state encoding.
package kabeta_int_ctrl_pkg;

   localparam logic [1:0] INT_REG_PEND = 2'd0;
   localparam logic [1:0] INT_REG_MASK = 2'd1;
   localparam logic [1:0] INT_REG_MODE = 2'd2;
   localparam logic [1:0] INT_REG_STAT = 2'd3;

   typedef enum logic [1:0] {
      INT_ST_IDLE    = 2'd0,
      INT_ST_REQ     = 2'd1,
      INT_ST_SERVICE = 2'd2
   } int_state_e;

endpackage

// File: rtl/kabeta_int_ctrl_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous interrupt line.
module kabeta_int_sync
   import kabeta_int_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic Sys_Clock,
   input  logic Sys_Reset,
   input  logic i_async,
   output logic o_sync
);

   logic [SYNC_STAGES-1:0] r_chain;

   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/kabeta_int_ctrl.sv
// Prioritised interrupt controller with a single request/ack/EOI handshake to the core.
// Define KABETA_INT_EDGE_MODE_EN to build the MODE register and per-channel edge detection.
//
// state          | meaning
// INT_ST_IDLE    | no request outstanding; arbitrates eligible channels
// INT_ST_REQ     | EIC_I_Req high with latched id; waits for EIC_Ack
// INT_ST_SERVICE | core is servicing the latched id; waits for EOI write
module kabeta_int_ctrl
   import kabeta_int_ctrl_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int ID_W        = $clog2(NUM_CH),
   parameter int SYNC_STAGES = 2
) (
   input  logic              Sys_Clock,
   input  logic              Sys_Reset,
   input  logic [NUM_CH-1:0] IRQ_In,
   input  logic              IO_EnR,
   input  logic              IO_EnW,
   input  logic [1:0]        IO_Addr,
   input  logic [31:0]       IO_DataW,
   output logic [31:0]       IO_DataR,
   output logic              EIC_I_Req,
   output logic [ID_W-1:0]   EIC_I_Id,
   input  logic              EIC_Ack
);

   if (NUM_CH < 2 || NUM_CH > 32) begin : g_bad_num_ch
      $error("kabeta_int_ctrl: NUM_CH must be 2..32");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("kabeta_int_ctrl: SYNC_STAGES must be 2..3");
   end

   logic [NUM_CH-1:0] w_sync;
   logic [NUM_CH-1:0] w_rise;
   logic [NUM_CH-1:0] w_mode;
   logic [NUM_CH-1:0] w_wdata_ch;
   logic [NUM_CH-1:0] w_id_hot;
   logic [NUM_CH-1:0] w_ack_clr;
   logic [NUM_CH-1:0] w_clr;
   logic [NUM_CH-1:0] w_pend_nxt;
   logic [NUM_CH-1:0] w_elig;
   logic [ID_W-1:0]   w_win_id;
   logic              w_any;
   logic              w_lat_elig;
   logic              w_ack_in_req;
   logic              w_wr_pend;
   logic              w_wr_mask;
   logic              w_wr_mode;
   logic              w_wr_stat;
   logic [31:0]       w_rd;
   logic              w_unused;

   logic [NUM_CH-1:0] r_pend;
   logic [NUM_CH-1:0] r_mask;
   logic [31:0]       r_rdata;
   logic              r_req;
   logic [ID_W-1:0]   r_id;
   logic              r_active;
   int_state_e        r_state;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
      kabeta_int_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .Sys_Clock (Sys_Clock),
         .Sys_Reset (Sys_Reset),
         .i_async   (IRQ_In[g]),
         .o_sync    (w_sync[g])
      );
   end

   assign w_wr_pend  = IO_EnW && (IO_Addr == INT_REG_PEND);
   assign w_wr_mask  = IO_EnW && (IO_Addr == INT_REG_MASK);
   assign w_wr_mode  = IO_EnW && (IO_Addr == INT_REG_MODE);
   assign w_wr_stat  = IO_EnW && (IO_Addr == INT_REG_STAT);
   assign w_wdata_ch = IO_DataW[NUM_CH-1:0];
   assign w_unused   = ^IO_DataW;

`ifdef KABETA_INT_EDGE_MODE_EN
   logic [NUM_CH-1:0] r_sync_d;
   logic [NUM_CH-1:0] r_mode;

   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         r_sync_d <= '0;
         r_mode   <= '0;
      end else begin
         r_sync_d <= w_sync;
         if (w_wr_mode) begin
            r_mode <= w_wdata_ch;
         end
      end
   end

   assign w_rise = w_sync & ~r_sync_d;
   assign w_mode = r_mode;
`else
   logic w_unused_mode_wr;

   assign w_rise           = '0;
   assign w_mode           = '0;
   assign w_unused_mode_wr = w_wr_mode;
`endif

   assign w_ack_in_req = (r_state == INT_ST_REQ) && EIC_Ack;

   always_comb begin
      w_id_hot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_id_hot[i] = (r_id == ID_W'(i));
      end
   end

   assign w_ack_clr = w_ack_in_req ? w_id_hot : '0;
   assign w_clr     = (w_wr_pend ? w_wdata_ch : '0) | w_ack_clr;

   // Edge channels: a new rising edge beats any clear in the same cycle.
   assign w_pend_nxt = (w_mode & (w_rise | (r_pend & ~w_clr))) | (~w_mode & w_sync);

   assign w_elig     = r_pend & r_mask;
   assign w_any      = |w_elig;
   assign w_lat_elig = |(w_elig & w_id_hot);

   always_comb begin
      w_win_id = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_win_id = ID_W'(i);
         end
      end
   end

   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         r_pend <= '0;
         r_mask <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_wr_mask) begin
            r_mask <= w_wdata_ch;
         end
      end
   end

   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         r_state  <= INT_ST_IDLE;
         r_req    <= 1'b0;
         r_id     <= '0;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            INT_ST_IDLE: begin
               if (w_any) begin
                  r_state <= INT_ST_REQ;
                  r_req   <= 1'b1;
                  r_id    <= w_win_id;
               end
            end
            INT_ST_REQ: begin
               // An ack wins over a same-cycle loss of eligibility: the core has already taken it.
               if (EIC_Ack) begin
                  r_state  <= INT_ST_SERVICE;
                  r_req    <= 1'b0;
                  r_active <= 1'b1;
               end else if (!w_lat_elig) begin
                  r_state <= INT_ST_IDLE;
                  r_req   <= 1'b0;
               end
            end
            INT_ST_SERVICE: begin
               if (w_wr_stat) begin
                  r_state  <= INT_ST_IDLE;
                  r_active <= 1'b0;
               end
            end
            default: begin
               r_state  <= INT_ST_IDLE;
               r_req    <= 1'b0;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      w_rd = '0;
      case (IO_Addr)
         INT_REG_PEND: w_rd[NUM_CH-1:0] = r_pend;
         INT_REG_MASK: w_rd[NUM_CH-1:0] = r_mask;
         INT_REG_MODE: w_rd[NUM_CH-1:0] = w_mode;
         INT_REG_STAT: w_rd[ID_W:0]     = {r_active, r_id};
         default:      w_rd             = '0;
      endcase
   end

   // Read mux samples pre-write register values, so a same-cycle write is not visible.
   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         r_rdata <= '0;
      end else if (IO_EnR) begin
         r_rdata <= w_rd;
      end
   end

   assign IO_DataR  = r_rdata;
   assign EIC_I_Req = r_req;
   assign EIC_I_Id  = r_id;

endmodule

// File: tb/tb_kabeta_int_ctrl.sv
// Directed self-checking bench for kabeta_int_ctrl (default parameters).
module tb_kabeta_int_ctrl;
   import kabeta_int_ctrl_pkg::*;

   logic        Sys_Clock;
   logic        Sys_Reset;
   logic [7:0]  IRQ_In;
   logic        IO_EnR;
   logic        IO_EnW;
   logic [1:0]  IO_Addr;
   logic [31:0] IO_DataW;
   logic [31:0] IO_DataR;
   logic        EIC_I_Req;
   logic [2:0]  EIC_I_Id;
   logic        EIC_Ack;

   int n_tests;
   int n_fail;
   logic [31:0] d;

   kabeta_int_ctrl #(
      .NUM_CH      (8),
      .ID_W        (3),
      .SYNC_STAGES (2)
   ) dut (
      .Sys_Clock (Sys_Clock),
      .Sys_Reset (Sys_Reset),
      .IRQ_In    (IRQ_In),
      .IO_EnR    (IO_EnR),
      .IO_EnW    (IO_EnW),
      .IO_Addr   (IO_Addr),
      .IO_DataW  (IO_DataW),
      .IO_DataR  (IO_DataR),
      .EIC_I_Req (EIC_I_Req),
      .EIC_I_Id  (EIC_I_Id),
      .EIC_Ack   (EIC_Ack)
   );

   initial Sys_Clock = 1'b0;
   always #5 Sys_Clock = ~Sys_Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Sys_Clock);
      #1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      IO_EnW   = 1'b1;
      IO_Addr  = addr;
      IO_DataW = data;
      tick();
      IO_EnW   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] addr, output logic [31:0] data);
      IO_EnR  = 1'b1;
      IO_Addr = addr;
      tick();
      IO_EnR  = 1'b0;
      data    = IO_DataR;
   endtask

   task automatic ack();
      EIC_Ack = 1'b1;
      tick();
      EIC_Ack = 1'b0;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      Sys_Reset = 1'b1;
      IRQ_In    = '0;
      IO_EnR    = 1'b0;
      IO_EnW    = 1'b0;
      IO_Addr   = '0;
      IO_DataW  = '0;
      EIC_Ack   = 1'b0;
      repeat (3) tick();
      Sys_Reset = 1'b0;

      chk("rst_req", EIC_I_Req, 0);
      chk("rst_id", EIC_I_Id, 0);
      chk("rst_rdata", IO_DataR, 0);
      rd(INT_REG_MASK, d); chk("rst_mask", d, 0);
      rd(INT_REG_PEND, d); chk("rst_pend", d, 0);
      rd(INT_REG_STAT, d); chk("rst_stat", d, 0);

      wr(INT_REG_MASK, 32'hFF);
      rd(INT_REG_MASK, d); chk("mask_rw", d, 32'hFF);

      // level ch0: request appears exactly SYNC_STAGES+2 cycles after the input rises
      IRQ_In = 8'h01;
      repeat (3) tick();
      chk("lat_early", EIC_I_Req, 0);
      tick();
      chk("lat_req", EIC_I_Req, 1);
      chk("lat_id", EIC_I_Id, 0);
      ack();
      chk("ack_req_drop", EIC_I_Req, 0);
      rd(INT_REG_STAT, d); chk("stat_active", d, 32'h8);
      rd(INT_REG_PEND, d); chk("lvl_pend_ack", d, 32'h1);
      IRQ_In = 8'h00;
      repeat (4) tick();
      wr(INT_REG_STAT, 0);
      repeat (2) tick();
      chk("eoi_idle_req", EIC_I_Req, 0);
      rd(INT_REG_STAT, d); chk("eoi_stat", d, 0);

      // priority: ch2 beats ch5, then ch5 after EOI
      IRQ_In = 8'h24;
      repeat (4) tick();
      chk("prio_req", EIC_I_Req, 1);
      chk("prio_id2", EIC_I_Id, 2);
      ack();
      IRQ_In = 8'h20;
      repeat (4) tick();
      wr(INT_REG_STAT, 0);
      chk("eoi_gap", EIC_I_Req, 0);
      tick();
      chk("prio_req5", EIC_I_Req, 1);
      chk("prio_id5", EIC_I_Id, 5);
      ack();
      IRQ_In = 8'h00;
      repeat (4) tick();
      wr(INT_REG_STAT, 0);
      tick();

      // masked channel stays pending, unmasking raises the request
      wr(INT_REG_MASK, 0);
      IRQ_In = 8'h08;
      repeat (5) tick();
      chk("masked_noreq", EIC_I_Req, 0);
      rd(INT_REG_PEND, d); chk("masked_pend", d, 32'h08);
      wr(INT_REG_MASK, 32'h08);
      chk("unmask_lat", EIC_I_Req, 0);
      tick();
      chk("unmask_req", EIC_I_Req, 1);
      chk("unmask_id", EIC_I_Id, 3);
      wr(INT_REG_PEND, 32'h08);
      rd(INT_REG_PEND, d); chk("lvl_w1c_noeff", d, 32'h08);
      wr(INT_REG_STAT, 0);
      chk("eoi_in_req_ign", EIC_I_Req, 1);
      ack();
      IRQ_In = 8'h00;
      repeat (4) tick();
      wr(INT_REG_STAT, 0);
      tick();

      // level ch4 dropped while in REQ: request withdrawn, back to IDLE
      wr(INT_REG_MASK, 32'hFF);
      IRQ_In = 8'h10;
      repeat (4) tick();
      chk("drop_req_on", EIC_I_Req, 1);
      chk("drop_id", EIC_I_Id, 4);
      IRQ_In = 8'h00;
      repeat (3) tick();
      chk("drop_hold", EIC_I_Req, 1);
      tick();
      chk("drop_req_off", EIC_I_Req, 0);
      repeat (2) tick();
      chk("drop_stay_off", EIC_I_Req, 0);
      rd(INT_REG_STAT, d); chk("drop_stat_idle", d, 32'h4);
      ack();
      rd(INT_REG_STAT, d); chk("ack_idle_ign", d, 32'h4);
      tick();
      chk("rdata_hold", IO_DataR, 32'h4);

      // same-cycle read and write of MASK returns the old value
      IO_EnR   = 1'b1;
      IO_EnW   = 1'b1;
      IO_Addr  = INT_REG_MASK;
      IO_DataW = 32'h0F;
      tick();
      IO_EnR   = 1'b0;
      IO_EnW   = 1'b0;
      chk("rw_same_old", IO_DataR, 32'hFF);
      rd(INT_REG_MASK, d); chk("rw_same_new", d, 32'h0F);

      // reset during SERVICE abandons the interrupt
      IRQ_In = 8'h02;
      repeat (4) tick();
      chk("svc_req", EIC_I_Req, 1);
      chk("svc_id", EIC_I_Id, 1);
      ack();
      rd(INT_REG_STAT, d); chk("svc_stat", d, 32'h9);
      Sys_Reset = 1'b1;
      tick();
      Sys_Reset = 1'b0;
      chk("svc_rst_req", EIC_I_Req, 0);
      chk("svc_rst_id", EIC_I_Id, 0);
      chk("svc_rst_rdata", IO_DataR, 0);
      rd(INT_REG_MASK, d); chk("svc_rst_mask", d, 0);
      rd(INT_REG_STAT, d); chk("svc_rst_stat", d, 0);
      IRQ_In = 8'h00;
      repeat (4) tick();

      wr(INT_REG_MODE, 32'hFF);
      rd(INT_REG_MODE, d);
`ifdef KABETA_INT_EDGE_MODE_EN
      chk("mode_rw", d, 32'hFF);

      // edge ch0: one-cycle pulse is caught, ack clears pending
      wr(INT_REG_MASK, 32'hFF);
      wr(INT_REG_MODE, 32'h01);
      IRQ_In = 8'h01;
      tick();
      IRQ_In = 8'h00;
      repeat (2) tick();
      chk("edge_lat_early", EIC_I_Req, 0);
      tick();
      chk("edge_req", EIC_I_Req, 1);
      chk("edge_id", EIC_I_Id, 0);
      ack();
      rd(INT_REG_PEND, d); chk("edge_ack_clr", d, 0);
      rd(INT_REG_STAT, d); chk("edge_stat", d, 32'h8);
      wr(INT_REG_STAT, 0);
      tick();
      chk("edge_eoi_idle", EIC_I_Req, 0);

      // masked edge latches pending, unmask requests
      wr(INT_REG_MASK, 0);
      wr(INT_REG_MODE, 32'hFF);
      IRQ_In = 8'h08;
      tick();
      IRQ_In = 8'h00;
      repeat (4) tick();
      chk("edge_masked_noreq", EIC_I_Req, 0);
      rd(INT_REG_PEND, d); chk("edge_masked_pend", d, 32'h08);
      wr(INT_REG_MASK, 32'h08);
      tick();
      chk("edge_unmask_req", EIC_I_Req, 1);
      chk("edge_unmask_id", EIC_I_Id, 3);
      ack();
      wr(INT_REG_STAT, 0);
      wr(INT_REG_MASK, 0);

      // W1C alone clears; W1C colliding with a new edge loses
      IRQ_In = 8'h01;
      tick();
      IRQ_In = 8'h00;
      tick();
      wr(INT_REG_PEND, 32'h01);
      rd(INT_REG_PEND, d); chk("edge_set_wins", d, 32'h01);
      wr(INT_REG_PEND, 32'h01);
      rd(INT_REG_PEND, d); chk("edge_w1c", d, 0);
`else
      chk("mode_ro_zero", d, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
